// File: rtl/nes_poll_sequencer.sv
// Polls both NES controllers once per frame: drives the shared latch/clock protocol,
// samples the serial data lines through synchronizers and publishes active-high buttons.
module nes_poll_sequencer #(
  parameter int unsigned TICK_DIV = 150
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       data_left,
  input  logic       data_right,
  output logic       latch_left,
  output logic       clk_left,
  output logic       latch_right,
  output logic       clk_right,
  output logic [7:0] buttons_left,
  output logic [7:0] buttons_right,
  output logic       buttons_valid,
  output logic       busy
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StLatch, StClkHi, StClkLo, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            half_q, half_d;
  logic [2:0]      idx_q, idx_d;
  logic [1:0]      sync_l_q, sync_r_q;
  logic [7:0]      shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic            tick_end;

  assign tick_end = (cnt_q == CntMax);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    idx_d     = idx_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d = StLatch;
          cnt_d   = '0;
          half_d  = 1'b0;
          idx_d   = '0;
        end
      end
      StLatch: begin
        cnt_d = tick_end ? '0 : cnt_q + 1'b1;
        if (tick_end) begin
          half_d = 1'b1;
          // Latch spans two ticks; bit 0 is valid while latch is high.
          if (half_q) begin
            shift_l_d[0] = ~sync_l_q[1];
            shift_r_d[0] = ~sync_r_q[1];
            idx_d        = 3'd1;
            state_d      = StClkHi;
          end
        end
      end
      StClkHi: begin
        cnt_d = tick_end ? '0 : cnt_q + 1'b1;
        if (tick_end) begin
          shift_l_d[idx_q] = ~sync_l_q[1];
          shift_r_d[idx_q] = ~sync_r_q[1];
          state_d          = StClkLo;
        end
      end
      StClkLo: begin
        cnt_d = tick_end ? '0 : cnt_q + 1'b1;
        if (tick_end) begin
          if (idx_q == 3'd7) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StClkHi;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      half_q        <= 1'b0;
      idx_q         <= '0;
      sync_l_q      <= 2'b11;
      sync_r_q      <= 2'b11;
      shift_l_q     <= '0;
      shift_r_q     <= '0;
      latch_left    <= 1'b0;
      clk_left      <= 1'b0;
      latch_right   <= 1'b0;
      clk_right     <= 1'b0;
      buttons_left  <= '0;
      buttons_right <= '0;
      buttons_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      half_q        <= half_d;
      idx_q         <= idx_d;
      sync_l_q      <= {sync_l_q[0], data_left};
      sync_r_q      <= {sync_r_q[0], data_right};
      shift_l_q     <= shift_l_d;
      shift_r_q     <= shift_r_d;
      // Outputs are registered from the next state so pins track the FSM with no lag.
      latch_left    <= (state_d == StLatch);
      clk_left      <= (state_d == StClkHi);
      latch_right   <= (state_d == StLatch);
      clk_right     <= (state_d == StClkHi);
      busy          <= (state_d != StIdle);
      buttons_valid <= (state_d == StDone);
      if (state_d == StDone) begin
        buttons_left  <= shift_l_d;
        buttons_right <= shift_r_d;
      end
    end
  end

endmodule

// File: tb/tb_nes_poll_sequencer.sv
// Directed bench for nes_poll_sequencer: one instance at TICK_DIV=4 with controller models,
// one at TICK_DIV=2 with table-driven data lines.
module tb_nes_poll_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // TICK_DIV = 4 instance
  logic       ft4 = 1'b0;
  logic       dl4, dr4;
  logic       latch_l4, clk_l4, latch_r4, clk_r4, valid4, busy4;
  logic [7:0] bl4, br4;
  logic [7:0] pat_l4 = 8'h00, pat_r4 = 8'h00;
  int         idx_l4 = 0, idx_r4 = 0;
  logic       noise_en = 1'b0;
  logic [3:0] noise = 4'h0;

  // 4021-style controller: bit 0 while latched, next bit after each clock rise
  always @(posedge latch_l4) idx_l4 = 0;
  always @(posedge clk_l4)   idx_l4 = idx_l4 + 1;
  always @(posedge latch_r4) idx_r4 = 0;
  always @(posedge clk_r4)   idx_r4 = idx_r4 + 1;
  assign dl4 = noise_en ? noise[0] : ((idx_l4 < 8) ? ~pat_l4[idx_l4] : 1'b1);
  assign dr4 = noise_en ? noise[1] : ((idx_r4 < 8) ? ~pat_r4[idx_r4] : 1'b1);

  nes_poll_sequencer #(.TICK_DIV(4)) dut4 (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_tick   (ft4),
    .data_left    (dl4),
    .data_right   (dr4),
    .latch_left   (latch_l4),
    .clk_left     (clk_l4),
    .latch_right  (latch_r4),
    .clk_right    (clk_r4),
    .buttons_left (bl4),
    .buttons_right(br4),
    .buttons_valid(valid4),
    .busy         (busy4)
  );

  // TICK_DIV = 2 instance
  logic       ft2 = 1'b0;
  logic       dl2 = 1'b1, dr2 = 1'b1;
  logic       latch_l2, clk_l2, latch_r2, clk_r2, valid2, busy2;
  logic [7:0] bl2, br2;

  nes_poll_sequencer #(.TICK_DIV(2)) dut2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_tick   (ft2),
    .data_left    (dl2),
    .data_right   (dr2),
    .latch_left   (latch_l2),
    .clk_left     (clk_l2),
    .latch_right  (latch_r2),
    .clk_right    (clk_r2),
    .buttons_left (bl2),
    .buttons_right(br2),
    .buttons_valid(valid2),
    .busy         (busy2)
  );

  // Scan statistics gathered by scan4
  int lat_cyc, lat_rises, lat_first, lat_second, clk_rises, clk_hi;
  int vcount, vcyc, busy_last, mirror_err;
  logic [7:0] got_l, got_r;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses frame_tick in cycle 0 (and at t1..t3), observes cycles 1..win.
  task automatic scan4(input int t1, input int t2, input int t3, input int win);
    logic pl, pc;
    lat_cyc = 0; lat_rises = 0; lat_first = -1; lat_second = -1;
    clk_rises = 0; clk_hi = 0; vcount = 0; vcyc = -1; busy_last = -1; mirror_err = 0;
    got_l = 8'hxx; got_r = 8'hxx;
    ft4 = 1'b1;
    pl = latch_l4;
    pc = clk_l4;
    for (int c = 1; c <= win; c++) begin
      step();
      ft4 = (c == t1) || (c == t2) || (c == t3);
      if (latch_l4) lat_cyc++;
      if (latch_l4 && !pl) begin
        lat_rises++;
        if (lat_rises == 1) lat_first = c;
        else lat_second = c;
      end
      if (clk_l4 && !pc) clk_rises++;
      if (clk_l4) clk_hi++;
      if (latch_l4 !== latch_r4 || clk_l4 !== clk_r4) mirror_err++;
      if (valid4) begin
        vcount++;
        if (vcount == 1) begin
          vcyc  = c;
          got_l = bl4;
          got_r = br4;
        end
      end
      if (busy4) busy_last = c;
      pl = latch_l4;
      pc = clk_l4;
    end
    ft4 = 1'b0;
  endtask

  task automatic test_reset();
    int moved;
    reset_n  = 1'b0;
    noise_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      noise = 4'($urandom);
      ft4   = 1'($urandom);
      ft2   = 1'($urandom);
      dl2   = noise[2];
      dr2   = noise[3];
      step();
      total++;
      if ({latch_l4, clk_l4, latch_r4, clk_r4, bl4, br4, valid4, busy4} !== 22'h0) begin
        bad++;
        $display("FAIL reset_hold_t4 got=%h want=0",
                 {latch_l4, clk_l4, latch_r4, clk_r4, bl4, br4, valid4, busy4});
      end
      total++;
      if ({latch_l2, clk_l2, latch_r2, clk_r2, bl2, br2, valid2, busy2} !== 22'h0) begin
        bad++;
        $display("FAIL reset_hold_t2 got=%h want=0",
                 {latch_l2, clk_l2, latch_r2, clk_r2, bl2, br2, valid2, busy2});
      end
    end
    ft4 = 1'b0; ft2 = 1'b0; dl2 = 1'b1; dr2 = 1'b1; noise_en = 1'b0;
    reset_n = 1'b1;
    moved = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if ({latch_l4, clk_l4, latch_r4, clk_r4, bl4, br4, valid4, busy4,
           latch_l2, clk_l2, latch_r2, clk_r2, bl2, br2, valid2, busy2} !== 44'h0) moved++;
    end
    total++;
    if (moved !== 0) begin
      bad++;
      $display("FAIL idle_static cycles_changed=%0d want=0", moved);
    end
  endtask

  task automatic test_basic_scan();
    pat_l4 = 8'h09;
    pat_r4 = 8'h00;
    scan4(-1, -1, -1, 70);
    total++;
    if (lat_first !== 1 || lat_cyc !== 8 || lat_rises !== 1) begin
      bad++;
      $display("FAIL basic_latch first=%0d cycles=%0d rises=%0d want 1/8/1",
               lat_first, lat_cyc, lat_rises);
    end
    total++;
    if (clk_rises !== 7 || clk_hi !== 28) begin
      bad++;
      $display("FAIL basic_clk pulses=%0d hi_cycles=%0d want 7/28", clk_rises, clk_hi);
    end
    total++;
    if (vcyc !== 65 || vcount !== 1) begin
      bad++;
      $display("FAIL basic_valid cycle=%0d count=%0d want 65/1", vcyc, vcount);
    end
    total++;
    if (got_l !== 8'h09 || got_r !== 8'h00) begin
      bad++;
      $display("FAIL basic_buttons left=%h right=%h want 09/00", got_l, got_r);
    end
    total++;
    if (busy_last !== 65 || mirror_err !== 0) begin
      bad++;
      $display("FAIL basic_busy_mirror busy_last=%0d mirror_err=%0d want 65/0",
               busy_last, mirror_err);
    end
    total++;
    if (bl4 !== 8'h09 || br4 !== 8'h00 || busy4 !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold left=%h right=%h busy=%b want 09/00/0", bl4, br4, busy4);
    end
  endtask

  task automatic test_full_press();
    pat_l4 = 8'hFF;
    pat_r4 = 8'hFF;
    scan4(-1, -1, -1, 70);
    total++;
    if (got_l !== 8'hFF || got_r !== 8'hFF || vcyc !== 65) begin
      bad++;
      $display("FAIL full_press left=%h right=%h cycle=%0d want FF/FF/65", got_l, got_r, vcyc);
    end
    pat_r4 = 8'h00;
    scan4(-1, -1, -1, 70);
    total++;
    if (got_l !== 8'hFF || got_r !== 8'h00) begin
      bad++;
      $display("FAIL right_release left=%h right=%h want FF/00", got_l, got_r);
    end
  endtask

  task automatic test_busy_reject();
    scan4(10, 40, 65, 70);
    total++;
    if (vcount !== 1 || lat_rises !== 1 || vcyc !== 65) begin
      bad++;
      $display("FAIL busy_reject valids=%0d latches=%0d vcycle=%0d want 1/1/65",
               vcount, lat_rises, vcyc);
    end
    scan4(66, -1, -1, 75);
    total++;
    if (lat_rises !== 2 || lat_second !== 67) begin
      bad++;
      $display("FAIL tick_after_done latches=%0d second_at=%0d want 2/67", lat_rises, lat_second);
    end
    for (int i = 0; i < 70; i++) step();
  endtask

  task automatic test_reset_midscan();
    ft4 = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      step();
      ft4 = 1'b0;
    end
    total++;
    if (clk_l4 !== 1'b1 || busy4 !== 1'b1 || bl4 !== 8'hFF) begin
      bad++;
      $display("FAIL midscan_pre clk=%b busy=%b left=%h want 1/1/FF", clk_l4, busy4, bl4);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({latch_l4, clk_l4, latch_r4, clk_r4, busy4, valid4, bl4, br4} !== 22'h0) begin
      bad++;
      $display("FAIL midscan_async got=%h want=0",
               {latch_l4, clk_l4, latch_r4, clk_r4, busy4, valid4, bl4, br4});
    end
    step();
    step();
    reset_n = 1'b1;
    step();
    pat_l4 = 8'h5A;
    pat_r4 = 8'h81;
    scan4(-1, -1, -1, 70);
    total++;
    if (got_l !== 8'h5A || got_r !== 8'h81 || vcyc !== 65) begin
      bad++;
      $display("FAIL after_reset left=%h right=%h cycle=%0d want 5A/81/65", got_l, got_r, vcyc);
    end
  endtask

  task automatic test_min_div();
    // Sync capture edge each bit must already be present at (TICK_DIV=2 timing)
    int cap[8] = '{3, 5, 9, 13, 17, 21, 25, 29};
    logic [7:0] pl = 8'hA5;
    logic [7:0] pr = 8'h3C;
    logic [7:0] gl = 8'hxx;
    logic [7:0] gr = 8'hxx;
    int vc = -1;
    int k;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) step();
      ft2 = (c == 0);
      k = 8;
      for (int j = 7; j >= 0; j--) if (cap[j] >= c + 1) k = j;
      dl2 = (k < 8) ? ~pl[k] : 1'b1;
      dr2 = (k < 8) ? ~pr[k] : 1'b1;
      if (valid2 && vc < 0) begin
        vc = c;
        gl = bl2;
        gr = br2;
      end
    end
    total++;
    if (vc !== 33) begin
      bad++;
      $display("FAIL min_div_valid cycle=%0d want 33", vc);
    end
    total++;
    if (gl !== 8'hA5 || gr !== 8'h3C) begin
      bad++;
      $display("FAIL min_div_buttons left=%h right=%h want A5/3C", gl, gr);
    end
    total++;
    if (busy2 !== 1'b0 || bl2 !== 8'hA5) begin
      bad++;
      $display("FAIL min_div_end busy=%b left=%h want 0/A5", busy2, bl2);
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_full_press();
    test_busy_reject();
    test_reset_midscan();
    test_min_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
